vga_timing_gen: RTL and testbench

- Parametrised VGA timing and framebuffer-fetch engine; next generation of the fixed 640x480 VGA block.
- Sits in the pixel-clock domain between the framebuffer read port and the VGA pins.
- Adds the following over the fixed block:
  - fully programmable porches and sync polarity;
  - integer pixel-replication scaling;
  - framebuffer read-address generation;
  - latency-aligned sync/blanking pipeline and frame/line strobes.

---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-domain bundle between the timing engine, the framebuffer read port and the VGA pins.
// The master side is the timing generator; the slave side is memory plus display.
interface vga_timing_gen_if #(
  parameter int COLOR_DEPTH = 4,
  parameter int ADDR_W      = 19
);
  logic                     en;
  logic                     fb_rd_en;
  logic [ADDR_W-1:0]        fb_addr;
  logic [3*COLOR_DEPTH-1:0] fb_data;
  logic [COLOR_DEPTH-1:0]   vga_r;
  logic [COLOR_DEPTH-1:0]   vga_g;
  logic [COLOR_DEPTH-1:0]   vga_b;
  logic                     hsync;
  logic                     vsync;
  logic                     vga_visible;
  logic                     frame_start;
  logic                     line_start;

  modport master (
    input  en, fb_data,
    output fb_rd_en, fb_addr, vga_r, vga_g, vga_b,
           hsync, vsync, vga_visible, frame_start, line_start
  );

  modport slave (
    output en, fb_data,
    input  fb_rd_en, fb_addr, vga_r, vga_g, vga_b,
           hsync, vsync, vga_visible, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with framebuffer address generation, pixel replication
// and a sync/blanking pipeline matched to the framebuffer read latency.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int COLOR_DEPTH = 4,
  parameter int SCALE_SHIFT = 0,
  parameter int FETCH_LAT   = 2,
  parameter int ADDR_W      = 19
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int CW      = 3 * COLOR_DEPTH;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEGIN   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MASK     = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [2:0]    REP_LAST   = 3'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d, v_plus1;
  logic [ADDR_W-1:0] line_base_q, line_base_d, src_x_q, src_x_d;
  logic [2:0]        rep_q, rep_d;
  logic              h_wrap, v_wrap, active, hs_act, vs_act;
  logic [4:0]        sig0, sig_dly;

  logic              hsync_q, vsync_q, vis_q, fs_q, ls_q;
  logic [CW-1:0]     rgb_q;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    v_plus1 = v_cnt_q + VW'(1);
    active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_act  = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
    vs_act  = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
    sig0    = {(h_cnt_q == '0) && (v_cnt_q < V_ACT),
               (h_cnt_q == '0) && (v_cnt_q == '0),
               vs_act, hs_act, active};

    h_cnt_d     = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d     = v_cnt_q;
    src_x_d     = src_x_q;
    rep_d       = rep_q;
    line_base_d = line_base_q;

    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_plus1;
    end

    // src_x steps once per 2^SCALE_SHIFT replicated pixels
    if (h_wrap) begin
      src_x_d = '0;
      rep_d   = '0;
    end else if (active) begin
      if (rep_q == REP_LAST) begin
        rep_d   = '0;
        src_x_d = src_x_q + ADDR_W'(1);
      end else begin
        rep_d = rep_q + 3'd1;
      end
    end

    // Advance to the next source row only after its last replicated line
    if (h_wrap && v_wrap) begin
      line_base_d = '0;
    end else if (active && (h_cnt_q == H_ACT_LAST) && ((v_plus1 & V_MASK) == '0)) begin
      line_base_d = line_base_q + ROW_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      line_base_q <= '0;
      src_x_q     <= '0;
      rep_q       <= '0;
    end else if (bus.en) begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      line_base_q <= line_base_d;
      src_x_q     <= src_x_d;
      rep_q       <= rep_d;
    end
  end

  generate
    if (FETCH_LAT == 0) begin : g_nolat
      assign sig_dly = sig0;
    end else begin : g_lat
      logic [4:0] dly_q [FETCH_LAT];
      for (genvar gi = 0; gi < FETCH_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk) begin
            if (rst)         dly_q[gi] <= '0;
            else if (bus.en) dly_q[gi] <= sig0;
          end
        end else begin : g_next
          always_ff @(posedge clk) begin
            if (rst)         dly_q[gi] <= '0;
            else if (bus.en) dly_q[gi] <= dly_q[gi-1];
          end
        end
      end
      assign sig_dly = dly_q[FETCH_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      vis_q   <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      rgb_q   <= '0;
    end else if (bus.en) begin
      hsync_q <= sig_dly[1] ? HS_POL : ~HS_POL;
      vsync_q <= sig_dly[2] ? VS_POL : ~VS_POL;
      vis_q   <= sig_dly[0];
      fs_q    <= sig_dly[3];
      ls_q    <= sig_dly[4];
      rgb_q   <= sig_dly[0] ? bus.fb_data : '0;
    end
  end

  assign bus.fb_rd_en    = active & bus.en & ~rst;
  assign bus.fb_addr     = line_base_q + src_x_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.vga_visible = vis_q;
  assign bus.frame_start = fs_q;
  assign bus.line_start  = ls_q;
  assign bus.vga_r       = rgb_q[CW-1 -: COLOR_DEPTH];
  assign bus.vga_g       = rgb_q[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
  assign bus.vga_b       = rgb_q[COLOR_DEPTH-1:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Drives two differently configured timing engines through reset, free running, random
// enable gaps, a long freeze and a mid-frame reset, against a position-based reference model.
module tb_vga_timing_gen;
  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 4;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FL_A = 2, FL_B = 3;
  localparam int S_A = 0, S_B = 1;
  localparam int AW_A = 8, AW_B = 6;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vis;
    logic       fs;
    logic       ls;
    logic [11:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int   k   = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOR_DEPTH(4), .ADDR_W(AW_A)) bus_a ();
  vga_timing_gen_if #(.COLOR_DEPTH(4), .ADDR_W(AW_B)) bus_b ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_DEPTH(4),
    .SCALE_SHIFT(S_A), .FETCH_LAT(FL_A), .ADDR_W(AW_A)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_DEPTH(4),
    .SCALE_SHIFT(S_B), .FETCH_LAT(FL_B), .ADDR_W(AW_B)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Framebuffer models: return the read address FETCH_LAT enabled clocks later,
  // and nonzero junk whenever no read was issued.
  logic [11:0] mem_a [FL_A];
  logic [11:0] mem_b [FL_B];

  always @(posedge clk) begin
    if (en) begin
      mem_a[0] <= bus_a.fb_rd_en ? 12'(bus_a.fb_addr) : 12'($urandom_range(1, 4095));
      mem_a[1] <= mem_a[0];
      mem_b[0] <= bus_b.fb_rd_en ? 12'(bus_b.fb_addr) : 12'($urandom_range(1, 4095));
      mem_b[1] <= mem_b[0];
      mem_b[2] <= mem_b[1];
    end
  end

  assign bus_a.en      = en;
  assign bus_b.en      = en;
  assign bus_a.fb_data = mem_a[FL_A-1];
  assign bus_b.fb_data = mem_b[FL_B-1];

  function automatic bit act_of(input int p);
    return ((p % HT) < HA) && (((p / HT) % VT) < VA);
  endfunction

  function automatic int addr_of(input int p, input int s, input int aw);
    int mh, mv;
    mh = p % HT;
    mv = (p / HT) % VT;
    return ((mv >> s) * (HA >> s) + (mh >> s)) % (1 << aw);
  endfunction

  function automatic exp_t model(input int p, input int s, input int aw, input bit pol);
    exp_t e;
    int mh, mv;
    if (p < 0) begin
      e = '{hs: ~pol, vs: ~pol, vis: 1'b0, fs: 1'b0, ls: 1'b0, rgb: 12'h0};
    end else begin
      mh    = p % HT;
      mv    = (p / HT) % VT;
      e.vis = act_of(p);
      e.hs  = (mh >= HA + HFP && mh < HA + HFP + HSY) ? pol : ~pol;
      e.vs  = (mv >= VA + VFP && mv < VA + VFP + VSY) ? pol : ~pol;
      e.fs  = (mh == 0) && (mv == 0);
      e.ls  = (mh == 0) && (mv < VA);
      e.rgb = e.vis ? 12'(addr_of(p, s, aw)) : 12'h0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h pos=%0d", tag, obs, exp, k);
    end
  endtask

  // One clock: drive inputs, check read-port outputs, clock, check registered pins.
  task automatic cycle(input bit e, input bit r);
    exp_t ea, eb;
    en  = e;
    rst = r;
    #1;
    chk("rd_en_a", 32'(bus_a.fb_rd_en), 32'(e && !r && act_of(k)));
    chk("rd_en_b", 32'(bus_b.fb_rd_en), 32'(e && !r && act_of(k)));
    if (act_of(k)) begin
      chk("addr_a", 32'(bus_a.fb_addr), 32'(addr_of(k, S_A, AW_A)));
      chk("addr_b", 32'(bus_b.fb_addr), 32'(addr_of(k, S_B, AW_B)));
    end
    @(posedge clk);
    if (r)      k = 0;
    else if (e) k++;
    #1;
    ea = model(k - (FL_A + 1), S_A, AW_A, 1'b0);
    eb = model(k - (FL_B + 1), S_B, AW_B, 1'b1);
    chk("hsync_a", 32'(bus_a.hsync),       32'(ea.hs));
    chk("vsync_a", 32'(bus_a.vsync),       32'(ea.vs));
    chk("vis_a",   32'(bus_a.vga_visible), 32'(ea.vis));
    chk("fs_a",    32'(bus_a.frame_start), 32'(ea.fs));
    chk("ls_a",    32'(bus_a.line_start),  32'(ea.ls));
    chk("rgb_a",   32'({bus_a.vga_r, bus_a.vga_g, bus_a.vga_b}), 32'(ea.rgb));
    chk("hsync_b", 32'(bus_b.hsync),       32'(eb.hs));
    chk("vsync_b", 32'(bus_b.vsync),       32'(eb.vs));
    chk("vis_b",   32'(bus_b.vga_visible), 32'(eb.vis));
    chk("fs_b",    32'(bus_b.frame_start), 32'(eb.fs));
    chk("ls_b",    32'(bus_b.line_start),  32'(eb.ls));
    chk("rgb_b",   32'({bus_b.vga_r, bus_b.vga_g, bus_b.vga_b}), 32'(eb.rgb));
  endtask

  initial begin
    en  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with en high: rst must dominate
    repeat (3) cycle(1'b1, 1'b1);

    // Two full frames free running
    repeat (2 * HT * VT) cycle(1'b1, 1'b0);

    // Random enable gaps
    repeat (300) cycle($urandom_range(0, 3) != 0, 1'b0);

    // Long freeze in the middle of an active line
    for (int i = 0; i < 2 * HT * VT && !((k % HT) == 5 && ((k / HT) % VT) == 2); i++)
      cycle(1'b1, 1'b0);
    repeat (37) cycle(1'b0, 1'b0);
    repeat (HT * VT + 40) cycle(1'b1, 1'b0);

    // Reset in the middle of a frame, then restart
    for (int i = 0; i < 2 * HT * VT && !((k % HT) == 7 && ((k / HT) % VT) == 5); i++)
      cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (2 * HT * VT) cycle(1'b1, 1'b0);

    // Reset released while disabled: start counts from the first enabled cycle
    repeat (2) cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    repeat (HT * VT + 10) cycle(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
